alu_op_sequencer: RTL and testbench

- Sequencing controller in front of the calculator ALU datapath (logic, shift, CLA add/sub, int/float mul/div).
- Accepts one operation request at a time over a valid/ready handshake and issues it to the datapath.
- Waits for multi-cycle units to finish, with a timeout, then registers the result and keeps the previous result as the shift operand.
- Replaces free-running combinational result muxing with a clean registered result/lastresult pair.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_sequencer_if.sv | 44 ++++
 rtl/alu_seq_timeout.sv | 32 +++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the ALU op sequencer.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_FADD = 4'd4;
   localparam logic [3:0] OP_FSUB = 4'd5;
   localparam logic [3:0] OP_FMUL = 4'd6;
   localparam logic [3:0] OP_FDIV = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_NOR  = 4'd10;
   localparam logic [3:0] OP_NOT  = 4'd11;
   localparam logic [3:0] OP_LLS  = 4'd12;
   localparam logic [3:0] OP_LRS  = 4'd13;
   localparam logic [3:0] OP_AS   = 4'd14;
   localparam logic [3:0] OP_CS   = 4'd15;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   function automatic logic is_slow_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_FMUL) || (op == OP_FDIV);
   endfunction

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_LLS) || (op == OP_LRS) || (op == OP_AS) || (op == OP_CS);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, datapath and response signals of the ALU op sequencer.
// ALU_SEQ_PERF_EN adds the ops_done / err_count performance counters.
interface alu_op_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [63:0] req_a;
   logic [31:0] req_b;
   logic        unit_start;
   logic [3:0]  unit_op;
   logic [63:0] unit_a;
   logic [31:0] unit_b;
   logic        unit_done;
   logic        unit_err;
   logic [63:0] unit_result;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] result;
   logic [63:0] lastresult;
   logic        err;
   logic        busy;
`ifdef ALU_SEQ_PERF_EN
   logic [15:0] ops_done;
   logic [15:0] err_count;
`endif

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready, unit_done, unit_err, unit_result,
      input  req_ready, unit_start, unit_op, unit_a, unit_b, resp_valid, result, lastresult,
             err, busy
`ifdef ALU_SEQ_PERF_EN
      , ops_done, err_count
`endif
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready, unit_done, unit_err, unit_result,
      output req_ready, unit_start, unit_op, unit_a, unit_b, resp_valid, result, lastresult,
             err, busy
`ifdef ALU_SEQ_PERF_EN
      , ops_done, err_count
`endif
   );
endinterface

// File: rtl/alu_seq_timeout.sv
// Clearable up-counter used to bound the wait on a multi-cycle unit; tc_o flags TIMEOUT_CYCLES-1.
module alu_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == TC_VAL);
endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op at a time, waits (bounded) for multi-cycle units, registers result/lastresult.
// ALU_SEQ_PERF_EN adds saturating ops_done / err_count counters.
//
// state | meaning
// IDLE  | ready for a request, operands latched on accept
// EXEC  | unit_start pulse; fast ops captured here
// WAIT  | slow op in flight, counting toward timeout
// RESP  | resp_valid held until resp_ready
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input logic              clk,
   input logic              rst,
   alu_op_sequencer_if.slave bus
);
   logic [1:0]  state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [63:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] result_q, result_d;
   logic [63:0] lastresult_q, lastresult_d;
   logic        err_q, err_d;
   logic        cnt_clr, cnt_en, cnt_tc;

   alu_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      lastresult_d = lastresult_q;
      err_d        = err_q;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            op_d    = bus.req_op;
            // Shifts operate on the previous result, which becomes lastresult at capture.
            a_d     = is_shift_op(bus.req_op) ? {32'b0, result_q[31:0]} : bus.req_a;
            b_d     = bus.req_b;
            state_d = EXEC;
         end
         EXEC: if (is_slow_op(op_q)) begin
            cnt_clr = 1'b1;
            state_d = WAIT;
         end else begin
            lastresult_d = result_q;
            result_d     = bus.unit_result;
            err_d        = 1'b0;
            state_d      = RESP;
         end
         WAIT: begin
            cnt_en = 1'b1;
            if (bus.unit_done) begin
               lastresult_d = result_q;
               result_d     = bus.unit_result;
               err_d        = bus.unit_err;
               state_d      = RESP;
            end else if (cnt_tc) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         lastresult_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         lastresult_q <= lastresult_d;
         err_q        <= err_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.unit_start = (state_q == EXEC);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.busy       = (state_q != IDLE);
   assign bus.unit_op    = op_q;
   assign bus.unit_a     = a_q;
   assign bus.unit_b     = b_q;
   assign bus.result     = result_q;
   assign bus.lastresult = lastresult_q;
   assign bus.err        = err_q;

`ifdef ALU_SEQ_PERF_EN
   logic [15:0] ops_done_q, ops_done_d;
   logic [15:0] err_count_q, err_count_d;
   logic        resp_hs;

   assign resp_hs = (state_q == RESP) && bus.resp_ready;

   always_comb begin
      ops_done_d  = ops_done_q;
      err_count_d = err_count_q;
      if (resp_hs && (ops_done_q != 16'hFFFF))
         ops_done_d = ops_done_q + 16'd1;
      if (resp_hs && err_q && (err_count_q != 16'hFFFF))
         err_count_d = err_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_done_q  <= '0;
         err_count_q <= '0;
      end else begin
         ops_done_q  <= ops_done_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.ops_done  = ops_done_q;
   assign bus.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected responses, a monitor checks them.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   typedef struct packed {
      logic [63:0] result;
      logic [63:0] lastresult;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] slow_val;
   logic [63:0] fast_val;
   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb_q[$];

   alu_op_sequencer_if bus();

   alu_op_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Stand-in datapath: simple fast-op behaviour, slow results supplied by the stimulus.
   always_comb begin
      fast_val = 64'h0;
      case (bus.unit_op)
         OP_ADD, OP_FADD: fast_val = {32'b0, bus.unit_a[31:0] + bus.unit_b};
         OP_SUB, OP_FSUB: fast_val = {32'b0, bus.unit_a[31:0] - bus.unit_b};
         OP_AND:          fast_val = {32'b0, bus.unit_a[31:0] & bus.unit_b};
         OP_OR:           fast_val = {32'b0, bus.unit_a[31:0] | bus.unit_b};
         OP_NOR:          fast_val = {32'b0, ~(bus.unit_a[31:0] | bus.unit_b)};
         OP_NOT:          fast_val = {32'b0, ~bus.unit_a[31:0]};
         OP_LLS:          fast_val = {32'b0, bus.unit_a[31:0] << bus.unit_b[4:0]};
         OP_LRS, OP_AS, OP_CS: fast_val = {32'b0, bus.unit_a[31:0] >> bus.unit_b[4:0]};
         default:         fast_val = 64'h0;
      endcase
   end
   assign bus.unit_result = bus.unit_done ? slow_val : fast_val;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] r, input logic [63:0] l, input logic e);
      exp_t x;
      x.result     = r;
      x.lastresult = l;
      x.err        = e;
      sb_q.push_back(x);
   endtask

   task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [31:0] b);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 300) begin
         n_checks++; n_fail++;
         $display("FAIL send_ready_timeout: req_ready low for %0d cycles, expected high", n);
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 300) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout: busy for %0d cycles, expected return to IDLE", n);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: got result 0x%0h, expected no response", bus.result);
         end else begin
            e = sb_q.pop_front();
            check("resp_result", bus.result, e.result);
            check("resp_lastresult", bus.lastresult, e.lastresult);
            check("resp_err", {63'b0, bus.err}, {63'b0, e.err});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = 4'd0;
      bus.req_a      = 64'd0;
      bus.req_b      = 32'd0;
      bus.resp_ready = 1'b1;
      bus.unit_done  = 1'b0;
      bus.unit_err   = 1'b0;
      slow_val       = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", bus.result, 64'd0);
      check("rst_lastresult", bus.lastresult, 64'd0);
      check("rst_err", {63'b0, bus.err}, 64'd0);
      check("rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
      check("rst_unit_start", {63'b0, bus.unit_start}, 64'd0);
      check("rst_busy", {63'b0, bus.busy}, 64'd0);
      check("rst_unit_a", bus.unit_a, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // fast add, latency and single-cycle start pulse
      push(64'd12, 64'd0, 1'b0);
      send(OP_ADD, 64'd5, 32'd7);
      check("t1_unit_start_exec", {63'b0, bus.unit_start}, 64'd1);
      check("t1_resp_valid_c1", {63'b0, bus.resp_valid}, 64'd0);
      check("t1_unit_a", bus.unit_a, 64'd5);
      check("t1_unit_b", {32'b0, bus.unit_b}, 64'd7);
      @(posedge clk); #1;
      check("t1_unit_start_c2", {63'b0, bus.unit_start}, 64'd0);
      check("t1_resp_valid_c2", {63'b0, bus.resp_valid}, 64'd1);
      wait_idle();

      push(64'h0000_0000_8000_0001, 64'd12, 1'b0);
      send(OP_ADD, 64'h8000_0000, 32'd1);
      wait_idle();

      // shift takes previous result as operand
      push(64'd2, 64'h0000_0000_8000_0001, 1'b0);
      send(OP_LLS, 64'hFFFF, 32'd1);
      check("t3_shift_unit_a", bus.unit_a, 64'h0000_0000_8000_0001);
      wait_idle();

      // slow divide, done 10 cycles after start, stray request ignored
      push(64'h0000_0003_0000_0001, 64'd2, 1'b0);
      send(OP_DIV, 64'h0000_0009_0000_0003, 32'd3);
      check("t4_unit_a64", bus.unit_a, 64'h0000_0009_0000_0003);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         check("t4_req_ready_wait", {63'b0, bus.req_ready}, 64'd0);
         check("t4_no_restart", {63'b0, bus.unit_start}, 64'd0);
         bus.req_valid = (i >= 2 && i <= 5);
         bus.req_op    = OP_ADD;
      end
      bus.req_valid = 1'b0;
      bus.unit_done = 1'b1;
      bus.unit_err  = 1'b0;
      slow_val      = 64'h0000_0003_0000_0001;
      @(posedge clk); #1;
      bus.unit_done = 1'b0;
      check("t4_resp_after_done", {63'b0, bus.resp_valid}, 64'd1);
      wait_idle();

      // timeout: 64 WAIT cycles, result unchanged
      push(64'h0000_0003_0000_0001, 64'd2, 1'b1);
      send(OP_FMUL, 64'd1, 32'd2);
      begin
         int n = 0;
         while (bus.resp_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
         end
         check("t5_cycles_start_to_resp", 64'(n), 64'd65);
      end
      wait_idle();

      // done in the terminal cycle wins over timeout
      push(64'hABCD_0000_0000_1234, 64'h0000_0003_0000_0001, 1'b0);
      send(OP_FDIV, 64'd8, 32'd2);
      repeat (64) begin
         @(posedge clk); #1;
      end
      check("t6_no_early_timeout", {63'b0, bus.resp_valid}, 64'd0);
      bus.unit_done = 1'b1;
      bus.unit_err  = 1'b0;
      slow_val      = 64'hABCD_0000_0000_1234;
      @(posedge clk); #1;
      bus.unit_done = 1'b0;
      check("t6_resp_valid", {63'b0, bus.resp_valid}, 64'd1);
      wait_idle();

      // unit error propagates
      push(64'd0, 64'hABCD_0000_0000_1234, 1'b1);
      send(OP_DIV, 64'd5, 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus.unit_done = 1'b1;
      bus.unit_err  = 1'b1;
      slow_val      = 64'd0;
      @(posedge clk); #1;
      bus.unit_done = 1'b0;
      bus.unit_err  = 1'b0;
      wait_idle();

      // backpressure
      push(64'hFF, 64'd0, 1'b0);
      bus.resp_ready = 1'b0;
      send(OP_OR, 64'hF0, 32'h0F);
      @(posedge clk); #1;
      repeat (20) begin
         check("t7_hold_resp_valid", {63'b0, bus.resp_valid}, 64'd1);
         check("t7_hold_result", bus.result, 64'hFF);
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      wait_idle();

`ifdef ALU_SEQ_PERF_EN
      check("perf_ops_done", {48'b0, bus.ops_done}, 64'd8);
      check("perf_err_count", {48'b0, bus.err_count}, 64'd2);
`endif

      // async reset mid-WAIT, then stray done
      send(OP_MUL, 64'd3, 32'd4);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("t8_busy_in_wait", {63'b0, bus.busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("t8_rst_result", bus.result, 64'd0);
      check("t8_rst_lastresult", bus.lastresult, 64'd0);
      check("t8_rst_err", {63'b0, bus.err}, 64'd0);
      check("t8_rst_busy", {63'b0, bus.busy}, 64'd0);
      check("t8_rst_unit_op", {60'b0, bus.unit_op}, 64'd0);
      check("t8_rst_unit_a", bus.unit_a, 64'd0);
      check("t8_rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("t8_idle_after_rst", {63'b0, bus.req_ready}, 64'd1);
      bus.unit_done = 1'b1;
      slow_val      = 64'hBAD;
      @(posedge clk); #1;
      bus.unit_done = 1'b0;
      repeat (3) begin
         check("t8_stray_done_busy", {63'b0, bus.busy}, 64'd0);
         check("t8_stray_done_result", bus.result, 64'd0);
         @(posedge clk); #1;
      end
`ifdef ALU_SEQ_PERF_EN
      check("perf_ops_done_rst", {48'b0, bus.ops_done}, 64'd0);
`endif

      push(64'd3, 64'd0, 1'b0);
      send(OP_ADD, 64'd1, 32'd2);
      wait_idle();
`ifdef ALU_SEQ_PERF_EN
      check("perf_ops_done_final", {48'b0, bus.ops_done}, 64'd1);
      check("perf_err_count_final", {48'b0, bus.err_count}, 64'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
